// File: rtl/pwm_top.sv
// Single-channel PWM generator with push-button duty stepping, pinned out on io_in/io_out.
// Buttons are synchronized and edge-detected; each press moves duty by one step (1/PERIOD).
module pwm_top #(
  parameter int unsigned PERIOD     = 10,
  parameter int unsigned DUTY_RESET = 5,
  parameter int unsigned CNT_W      = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MaxDuty   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] ResetDuty = CNT_W'(DUTY_RESET);
  localparam logic [CNT_W-1:0] OneStep   = CNT_W'(1);

  logic             w_clk;
  logic             w_rst;
  logic             w_inc_btn;
  logic             w_dec_btn;
  logic [3:0]       w_unused_io;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] w_duty_d;
  logic             r_pwm_q;

  logic             r_inc_s1, r_inc_s2, r_inc_s3;
  logic             r_dec_s1, r_dec_s2, r_dec_s3;
  logic             w_inc_pulse;
  logic             w_dec_pulse;

  assign w_clk       = io_in[0];
  assign w_rst       = io_in[1];
  assign w_inc_btn   = io_in[2];
  assign w_dec_btn   = io_in[3];
  assign w_unused_io = io_in[7:4];

  // One pulse per rising edge of the synchronized button level.
  assign w_inc_pulse = r_inc_s2 & ~r_inc_s3;
  assign w_dec_pulse = r_dec_s2 & ~r_dec_s3;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_inc_s1 <= 1'b0;
      r_inc_s2 <= 1'b0;
      r_inc_s3 <= 1'b0;
      r_dec_s1 <= 1'b0;
      r_dec_s2 <= 1'b0;
      r_dec_s3 <= 1'b0;
    end else begin
      r_inc_s1 <= w_inc_btn;
      r_inc_s2 <= r_inc_s1;
      r_inc_s3 <= r_inc_s2;
      r_dec_s1 <= w_dec_btn;
      r_dec_s2 <= r_dec_s1;
      r_dec_s3 <= r_dec_s2;
    end
  end

  always_comb begin
    w_cnt_d = r_cnt + OneStep;
    if (r_cnt == LastCnt) begin
      w_cnt_d = '0;
    end
  end

  // Simultaneous presses cancel; both ends saturate.
  always_comb begin
    w_duty_d = r_duty;
    case ({w_inc_pulse, w_dec_pulse})
      2'b10: begin
        if (r_duty != MaxDuty) begin
          w_duty_d = r_duty + OneStep;
        end
      end
      2'b01: begin
        if (r_duty != '0) begin
          w_duty_d = r_duty - OneStep;
        end
      end
      default: begin
        w_duty_d = r_duty;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt   <= '0;
      r_duty  <= ResetDuty;
      r_pwm_q <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_duty  <= w_duty_d;
      r_pwm_q <= (r_cnt < r_duty);
    end
  end

  assign io_out = {6'b000000, ~r_pwm_q, r_pwm_q};

endmodule

// File: tb/tb_pwm_top.sv
// Directed bench for pwm_top: a cycle model pushes expected io_out per edge, the
// sampler pops and compares at the following falling edge.
module tb_pwm_top;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       inc  = 1'b0;
  logic       dec  = 1'b0;
  logic [3:0] junk = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_checks = 0;
  int n_err    = 0;
  string tag = "init";

  // Reference model state
  int   m_cnt;
  int   m_duty;
  logic m_pwm;
  logic m_last_inc, m_last_dec;
  logic m_p1_inc, m_p1_dec, m_p2_inc, m_p2_dec;
  logic [7:0] exp_q[$];

  assign io_in = {junk, dec, inc, rst, clk};

  pwm_top #(
    .PERIOD    (10),
    .DUTY_RESET(5),
    .CNT_W     (4)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_cnt      = 0;
    m_duty     = 5;
    m_pwm      = 1'b0;
    m_last_inc = 1'b0;
    m_last_dec = 1'b0;
    m_p1_inc   = 1'b0;
    m_p1_dec   = 1'b0;
    m_p2_inc   = 1'b0;
    m_p2_dec   = 1'b0;
    exp_q.delete();
  endtask

  // A button rise sampled at edge k changes duty at edge k+2.
  task automatic model_edge(input logic b_inc, input logic b_dec);
    m_pwm = (m_cnt < m_duty);
    m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
    if (m_p2_inc && !m_p2_dec && m_duty < 10) m_duty = m_duty + 1;
    else if (m_p2_dec && !m_p2_inc && m_duty > 0) m_duty = m_duty - 1;
    m_p2_inc   = m_p1_inc;
    m_p2_dec   = m_p1_dec;
    m_p1_inc   = b_inc & ~m_last_inc;
    m_p1_dec   = b_dec & ~m_last_dec;
    m_last_inc = b_inc;
    m_last_dec = b_dec;
    exp_q.push_back({6'b000000, ~m_pwm, m_pwm});
  endtask

  task automatic check_now(input string name, input logic [7:0] want);
    n_checks++;
    assert (io_out === want) else begin
      n_err++;
      $error("FAIL %s: io_out=%b expected=%b", name, io_out, want);
    end
  endtask

  // Called at a falling edge: drive, clock, model, then sample at next falling edge.
  task automatic step(input logic b_inc, input logic b_dec);
    logic [7:0] want;
    inc  = b_inc;
    dec  = b_dec;
    junk = 4'($urandom);
    @(posedge clk);
    model_edge(b_inc, b_dec);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, io_out=%b expected=<entry>", tag, io_out);
    end else begin
      want = exp_q.pop_front();
      assert (io_out === want) else begin
        n_err++;
        $error("FAIL %s: io_out=%b expected=%b", tag, io_out, want);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press(input logic b_inc, input logic b_dec);
    step(b_inc, b_dec);
    idle(4);
  endtask

  // Reset lands between clock edges; outputs must react without a clock.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_now("async_reset", 8'h02);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_now("reset_hold", 8'h02);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check_now("power_on_reset", 8'h02);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_now("reset_hold", 8'h02);
    rst = 1'b0;

    tag = "free_run_50pct";
    idle(30);

    tag = "inc_pulse";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle(25);

    tag = "inc_hold";
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
    idle(20);

    tag = "inc_saturate";
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    idle(15);
    tag = "inc_sixth_press";
    press(1'b1, 1'b0);
    idle(15);

    tag = "dec_saturate";
    apply_reset();
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1);
    idle(20);

    tag = "inc_dec_same";
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    idle(25);

    tag = "duty8_then_reset";
    apply_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    idle(7);
    apply_reset();
    tag = "after_reset_50pct";
    idle(25);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_top.md
Name: pwm_top

Overview:
- Single-channel PWM generator with push-button duty control, wrapped in the 8-bit io_in/io_out pin interface.
- Two button inputs step the duty cycle up or down in 10% increments.
- Outputs are the PWM waveform and its complement.
- Sits at chip top level; every signal is carried on io_in/io_out.

Parameters:
- PERIOD, 10, PWM period in clock cycles; also the number of duty steps.
- DUTY_RESET, 5, duty value loaded on reset (50%).
- CNT_W, 4, width of the period counter and duty register; must satisfy 2^CNT_W > PERIOD.

Ports:
- io_in[0]  input  1  clk; all state updates on its rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  increase_duty button, asynchronous to clk.
- io_in[3]  input  1  decrease_duty button, asynchronous to clk.
- io_in[7:4]  input  4  unused, ignored.
- io_out[0]  output  1  pwm_out.
- io_out[1]  output  1  pwm_neg_out, always the inverse of pwm_out.
- io_out[7:2]  output  6  tied to 0.
- The module's actual port list is io_in[7:0] and io_out[7:0].

Behaviour:
- Reset (async, active-high) clears or loads all state immediately:
  - cnt=0, duty=DUTY_RESET, synchronizer and edge registers=0, pwm_q=0.
  - Outputs during reset: pwm_out=0, pwm_neg_out=1, io_out[7:2]=0.
- Period counter cnt:
  - Increments every clock.
  - Wraps from PERIOD-1 to 0.
- Output register pwm_q:
  - Loads (cnt < duty) every clock, so output is one cycle behind the compare.
  - pwm_out=pwm_q; pwm_neg_out=~pwm_q (combinational inverse, never equal).
- Duty register duty:
  - Range 0..PERIOD; duty cycle = duty/PERIOD.
  - duty=0: pwm_out constantly 0.
  - duty=PERIOD: pwm_out constantly 1.
  - Otherwise pwm_out is high for exactly duty consecutive cycles per PERIOD-cycle frame.
- Button conditioning, identical per button:
  - 2-flop synchronizer (s1, s2), then a delay flop s3.
  - Press pulse = s2 & ~s3; one pulse per rising edge of the button, regardless of hold length.
  - Holding a button causes no auto-repeat.
  - Latency: input high before rising edge k, so duty updates at edge k+2 and pwm_out reflects the new duty from edge k+3 onward.
- Duty update on each clock:
  - inc pulse only: duty+1, saturating at PERIOD.
  - dec pulse only: duty-1, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Neither: hold.
- Duty changes take effect immediately in the compare, mid-frame; the counter is not restarted.
- Reset asserted mid-operation discards any pending press pulses. After release, a button already held high produces one press pulse once synchronized.
- io_in[7:4] have no effect.

Test Plan:
- Reset then free-run 30 clocks: pwm_out high 5 cycles / low 5 cycles per 10-cycle frame; pwm_neg_out always the inverse; io_out[7:2]=0.
- One increase pulse (high 3 clocks): duty 5->6; pwm_out high 6 of 10 cycles. Holding increase high 50 clocks still yields only +1.
- Five increase presses, each separated by 4 low clocks: duty saturates at 10; pwm_out constant 1, pwm_neg_out constant 0. A sixth press leaves both unchanged.
- Ten decrease presses from reset: duty saturates at 0; pwm_out constant 0, pwm_neg_out constant 1.
- Increase and decrease asserted on the same clock: duty stays 5; waveform unchanged.
- Assert reset asynchronously mid-frame after duty=8: outputs go to pwm_out=0, pwm_neg_out=1 without a clock edge. After release, waveform returns to 50%.
